otp_auth_ctrl: RTL

//  Controller for the OTP authenticator. Owns an 8-bit LFSR, snapshots a 2-digit hex OTP on otp_latch,

---
 rtl/otp_auth_ctrl.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/otp_auth_ctrl.sv
// otp_auth_ctrl: OTP authenticator controller.
// Owns an 8-bit Fibonacci LFSR, captures a 2-digit hex OTP, collects two user
// digits, compares them, enforces an entry timeout and an attempt lockout, and
// drives a multiplexed 2-digit seven-segment display.
// Optional build macro: OTP_MASK_EN blanks the OTP digits once entry has begun
// and while locked.
module otp_auth_ctrl #(
    parameter logic [7:0]  LFSR_SEED      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned MAX_ATTEMPTS   = 3,
    parameter int unsigned REFRESH_DIV    = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       otp_latch,
    input  logic       user_latch,
    input  logic [3:0] user_in,
    output logic [6:0] lfsr_out,
    output logic [6:0] user_out,
    output logic [1:0] an,
    output logic       match,
    output logic       fail,
    output logic       locked
);

    localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned REF_W   = $clog2(REFRESH_DIV);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENTRY = 2'd1,
        ST_CHECK = 2'd2,
        ST_LOCK  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [7:0]         lfsr_q, lfsr_d;
    logic [7:0]         otp_q, otp_d;
    logic               captured_q, captured_d;
    logic [3:0]         dig1_q, dig1_d;
    logic [3:0]         dig0_q, dig0_d;
    logic [1:0]         idx_q, idx_d;
    logic [3:0]         attempts_q, attempts_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [REF_W-1:0]   ref_cnt_q, ref_cnt_d;
    logic               scan_q, scan_d;
    logic               match_q, match_d;
    logic               fail_q, fail_d;
    logic               locked_q, locked_d;
    logic [1:0]         an_q, an_d;
    logic [6:0]         lfsr_out_q, lfsr_out_d;
    logic [6:0]         user_out_q, user_out_d;

    logic [3:0]         att_inc;
    logic               otp_mask;
    logic [3:0]         otp_digit;

    // Hex digit to {g..a} active-high segments.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Next-state logic: LFSR, FSM, attempt counter, timer and display scan.
    always_comb begin
        state_d    = state_q;
        lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        otp_d      = otp_q;
        captured_d = captured_q;
        dig1_d     = dig1_q;
        dig0_d     = dig0_q;
        idx_d      = idx_q;
        attempts_d = attempts_q;
        timer_d    = timer_q;
        match_d    = 1'b0;
        fail_d     = 1'b0;
        att_inc    = (attempts_q == 4'hF) ? attempts_q : attempts_q + 4'd1;

        case (state_q)
            ST_IDLE: begin
                if (otp_latch) begin
                    otp_d      = lfsr_q;
                    captured_d = 1'b1;
                    dig1_d     = 4'h0;
                    dig0_d     = 4'h0;
                    idx_d      = 2'd0;
                    timer_d    = TIMER_W'(TIMEOUT_CYCLES);
                    state_d    = ST_ENTRY;
                end
            end
            ST_ENTRY: begin
                // A new capture beats both the timeout and a pending digit.
                if (otp_latch) begin
                    otp_d   = lfsr_q;
                    dig1_d  = 4'h0;
                    dig0_d  = 4'h0;
                    idx_d   = 2'd0;
                    timer_d = TIMER_W'(TIMEOUT_CYCLES);
                end else if (timer_q <= TIMER_W'(1)) begin
                    timer_d    = '0;
                    fail_d     = 1'b1;
                    attempts_d = att_inc;
                    state_d    = ST_IDLE;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                    if (user_latch) begin
                        if (idx_q == 2'd0) begin
                            dig1_d = user_in;
                            idx_d  = 2'd1;
                        end else begin
                            dig0_d  = user_in;
                            idx_d   = 2'd2;
                            state_d = ST_CHECK;
                        end
                    end
                end
            end
            ST_CHECK: begin
                if ({dig1_q, dig0_q} == otp_q) begin
                    match_d    = 1'b1;
                    attempts_d = 4'd0;
                    state_d    = ST_IDLE;
                end else begin
                    fail_d     = 1'b1;
                    attempts_d = att_inc;
                    if (32'(att_inc) >= MAX_ATTEMPTS) begin
                        state_d = ST_LOCK;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_LOCK;
            end
        endcase

        locked_d = (state_d == ST_LOCK);

        if (ref_cnt_q == REF_W'(REFRESH_DIV - 1)) begin
            ref_cnt_d = '0;
            scan_d    = ~scan_q;
        end else begin
            ref_cnt_d = ref_cnt_q + REF_W'(1);
            scan_d    = scan_q;
        end
    end

    // Display drive: scan select, OTP digit (optionally masked) and entered digit.
    always_comb begin
`ifdef OTP_MASK_EN
        otp_mask = ((state_q == ST_ENTRY) && (idx_q != 2'd0)) ||
                   (state_q == ST_CHECK) || (state_q == ST_LOCK);
`else
        otp_mask = 1'b0;
`endif
        otp_digit  = scan_q ? otp_q[3:0] : otp_q[7:4];
        an_d       = scan_q ? 2'b10 : 2'b01;
        lfsr_out_d = (captured_q && !otp_mask) ? hex_to_seg(otp_digit) : 7'h00;
        if (!scan_q) begin
            user_out_d = (idx_q >= 2'd1) ? hex_to_seg(dig1_q) : 7'h00;
        end else begin
            user_out_d = (idx_q >= 2'd2) ? hex_to_seg(dig0_q) : 7'h00;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            lfsr_q     <= LFSR_SEED;
            otp_q      <= 8'h00;
            captured_q <= 1'b0;
            dig1_q     <= 4'h0;
            dig0_q     <= 4'h0;
            idx_q      <= 2'd0;
            attempts_q <= 4'd0;
            timer_q    <= '0;
            ref_cnt_q  <= '0;
            scan_q     <= 1'b0;
            match_q    <= 1'b0;
            fail_q     <= 1'b0;
            locked_q   <= 1'b0;
            an_q       <= 2'b11;
            lfsr_out_q <= 7'h00;
            user_out_q <= 7'h00;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            otp_q      <= otp_d;
            captured_q <= captured_d;
            dig1_q     <= dig1_d;
            dig0_q     <= dig0_d;
            idx_q      <= idx_d;
            attempts_q <= attempts_d;
            timer_q    <= timer_d;
            ref_cnt_q  <= ref_cnt_d;
            scan_q     <= scan_d;
            match_q    <= match_d;
            fail_q     <= fail_d;
            locked_q   <= locked_d;
            an_q       <= an_d;
            lfsr_out_q <= lfsr_out_d;
            user_out_q <= user_out_d;
        end
    end

    assign lfsr_out = lfsr_out_q;
    assign user_out = user_out_q;
    assign an       = an_q;
    assign match    = match_q;
    assign fail     = fail_q;
    assign locked   = locked_q;

endmodule
